mult_div_seq_32: RTL and testbench
==================================

# mult_div_seq_32

Sequential 32-bit multiply/divide unit for the MIPS datapath; the multi-cycle back end the ALU hands `mult`/`multu`/`div`/`divu` operations to through a start/busy/done handshake. It replaces single-cycle `*` and `/` with a radix-2 shift-add multiplier and a restoring divider, sharing one 64-bit working register. Results land in HI/LO form: product `{hi, lo}`; quotient in `lo`, remainder in `hi`.

## Interface

- `WIDTH`, default 32: operand width. Only 32 is supported; iteration count equals `WIDTH`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: operation. 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `a` in 32: multiplicand or dividend; captured when start is accepted.
- `b` in 32: multiplier or divisor; captured when start is accepted.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when `hi`/`lo` update.
- `hi` out 32: product[63:32] or remainder.
- `lo` out 32: product[31:0] or quotient.

## Operation

- FSM states:
  - IDLE: `start`=1 captures `|a|`, `|b|` (unsigned for `multu`/`divu`) and the result signs, then goes to MUL or DIV.
  - MUL / DIV: run 32 iterations, counted by a 5-bit counter.
  - FIX: applies sign correction, writes `hi`/`lo`, then returns to IDLE.
- MUL iteration: if accumulator LSB = 1, add the multiplicand into the upper half; then shift right 1, carry included.
- DIV iteration: shift {rem, quot} left 1, trial subtract the divisor; if the result is non-negative, keep it and set the quotient LSB.
- Signed fixup:
  - Product negated if `a`, `b` signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: `lo` = FFFFFFFF, `hi` = `a`, with full latency and no exception. Applies to both `div` and `divu`.
- Signed overflow: 80000000 / FFFFFFFF gives `lo` = 80000000, `hi` = 0.
- `start` while `busy` is ignored, with no queuing; operands and `op` must be held only in the accept cycle.
- `hi`/`lo` hold their last result until the next FIX.

## Timing

- Reset values:
  - `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.
  - State = IDLE, counter = 0.
- Accept edge E0 (IDLE, `start`=1): `busy` = 1 from after E0.
- Iterations occur on E1..E32; FIX on E33.
- After E33: `busy` = 0, `done` = 1 for exactly one cycle, `hi`/`lo` valid. Fixed 33-cycle latency for all ops, including divide by zero.
- Back-to-back: `start` in the `done` cycle is accepted, since the state is IDLE.
- Reset mid-operation: abort immediately, return to the reset values above, and emit no `done`.

## Configuration

- `MULT_DIV_DIVIDER_EN` defined: divider datapath and DIV state compiled in, with behaviour as above.
- Undefined: no divider logic.
  - `div`/`divu` are still accepted, with `busy` high for one cycle.
  - `done` pulses after E1 with `hi` = `lo` = 0.
  - Multiply behaviour and latency are unchanged.

## Structure

- Package `mult_div_pkg`:
  - `op` encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - FSM state typedef (IDLE, MUL, DIV, FIX).
  - Constant `ITERATIONS` = 32.
- One sub-module, `mult_div_sign_fix`: combinational negation and remainder-sign logic, plus the divide-by-zero and overflow overrides used in FIX.
- Top module holds the FSM, counter, 64-bit working register and divisor/multiplicand register.

## Test plan

- `mult` a=FFFFFFFD (-3), b=00000007 -> `hi`=FFFFFFFF, `lo`=FFFFFFEB; `done` exactly 33 cycles after the accept edge, `busy` high E1..E33.
- `multu` a=FFFFFFFF, b=FFFFFFFF -> `hi`=FFFFFFFE, `lo`=00000001; `mult` with the same operands -> `hi`=0, `lo`=1.
- `div` a=FFFFFFF9 (-7), b=2 -> `lo`=FFFFFFFD, `hi`=FFFFFFFF; `divu` a=64, b=7 -> `lo`=E, `hi`=2.
- `div` a=5, b=0 -> `lo`=FFFFFFFF, `hi`=5 after 33 cycles; `div` a=80000000, b=FFFFFFFF -> `lo`=80000000, `hi`=0.
- `start` pulsed at cycle 5 of an operation -> ignored, with the original result and timing unchanged; `reset` asserted at cycle 10 -> `busy`=0 and `hi`=`lo`=0 immediately, and no `done` follows.
- With `MULT_DIV_DIVIDER_EN` undefined: `div` a=9, b=3 -> `done` after E1, `hi`=`lo`=0; `mult` 6 × 7 -> `lo`=2A after 33 cycles.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Purpose : shared encodings, FSM state type and per-operation metadata for mult_div_seq_32.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Everything the FIX cycle needs to know about the operation in flight.
    typedef struct packed {
        logic is_div;    // result is {rem, quot} rather than a product
        logic neg_res;   // negate product / quotient
        logic neg_rem;   // remainder takes the (negative) dividend sign
        logic div_zero;  // divisor was zero
        logic ovf;       // signed 0x80000000 / -1
    } meta_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Purpose : combinational sign correction of the raw working register, plus divide-by-zero
//           and signed-overflow overrides; feeds hi/lo in the FIX cycle.
// Latency : 0 cycles (pure combinational). Backpressure: none.
// Ports   : acc (raw 64-bit product or {rem, quot}), meta (operation flags) -> hi_fix, lo_fix.
module mult_div_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  meta_t              meta,
    output logic [WIDTH-1:0]   hi_fix,
    output logic [WIDTH-1:0]   lo_fix
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = meta.neg_res ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
        quot = meta.neg_res ? (~acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc[WIDTH-1:0];
        rem  = meta.neg_rem ? (~acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                            : acc[2*WIDTH-1:WIDTH];

        hi_fix = prod[2*WIDTH-1:WIDTH];
        lo_fix = prod[WIDTH-1:0];
        if (meta.is_div) begin
            hi_fix = rem;
            lo_fix = quot;
            // A zero divisor already leaves |a| in the remainder (restored to a's sign
            // above); only the quotient needs forcing to all ones.
            if (meta.div_zero) begin
                lo_fix = '1;
            end
            if (meta.ovf) begin
                lo_fix = {1'b1, {(WIDTH-1){1'b0}}};
                hi_fix = '0;
            end
        end
    end

endmodule

// File: rtl/mult_div_seq_32.sv
// Purpose : sequential 32-bit mult/multu/div/divu unit, radix-2 shift-add / restoring divide.
// Latency : 33 cycles from the accept edge to done (1 cycle for div/divu without divider).
// Backpressure: start is only sampled while idle; a start during busy is dropped, not queued.
// Ports   : clock, reset (async, active-high); start/op/a/b request; busy, done pulse, hi/lo result.
// Config  : define MULT_DIV_DIVIDER_EN to build the divider; otherwise div ops return 0 after one cycle.
module mult_div_seq_32
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    state_t             state;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] acc;     // multiply: {partial, multiplier}; divide: {rem, quot}
    logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
    meta_t              meta;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_abs     = abs32(a, a_neg);
        b_abs     = abs32(b, b_neg);
        // Carry out of the add is shifted back in as the new MSB.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end

`ifdef MULT_DIV_DIVIDER_EN
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic               ovf_det;

    always_comb begin
        // The shifted remainder can need WIDTH+1 bits when the divisor is above 2^(WIDTH-1).
        div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
        div_next = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        ovf_det  = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end
`endif

    mult_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .acc    (acc),
        .meta   (meta),
        .hi_fix (hi_fix),
        .lo_fix (lo_fix)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            meta  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (op[1]) begin
`ifdef MULT_DIV_DIVIDER_EN
                            acc   <= {{WIDTH{1'b0}}, a_abs};
                            opnd  <= b_abs;
                            meta  <= '{1'b1, a_neg ^ b_neg, a_neg, (b == '0), ovf_det};
                            state <= DIV;
`else
                            // No divider: a zeroed register yields hi = lo = 0 in FIX.
                            acc   <= '0;
                            opnd  <= '0;
                            meta  <= '0;
                            state <= FIX;
`endif
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, b_abs};
                            opnd  <= a_abs;
                            meta  <= '{1'b0, a_neg ^ b_neg, 1'b0, 1'b0, 1'b0};
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                DIV: begin
`ifdef MULT_DIV_DIVIDER_EN
                    acc <= div_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
`else
                    state <= IDLE;
`endif
                end
                FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq_32.sv
// Purpose : self-checking bench for mult_div_seq_32 with a queue scoreboard and a done monitor.
// Latency : checks the 33-cycle (or 1-cycle divider-less) accept-to-done latency per operation.
// Backpressure: stimulus waits for busy low before issuing; mid-operation starts must be dropped.
module tb_mult_div_seq_32;
    import mult_div_pkg::*;

`ifdef MULT_DIV_DIVIDER_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    mult_div_seq_32 #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clock) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
                check({mon_e.name, "_lat"}, 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input bit push = 1'b1);
        int guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait: got busy=%b expected 0 within 100 cycles", nm, busy);
        end
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        if (push) sb.push_back('{eh, el, cyc + 1, lat, nm});
        @(negedge clock);
        // Scramble the operands to prove they were captured on the accept edge.
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
        check({nm, "_busy"}, 32'(busy), 32'h1);
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        issue("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
        issue("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        issue("mult_m1",    OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33);
        issue("mult_nn",    OP_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 33);
        issue("mult_pmax",  OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 33);

        issue("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h00000002,
              DIV_EN ? 32'hFFFFFFFF : 32'h0, DIV_EN ? 32'hFFFFFFFD : 32'h0, DIV_EN ? 33 : 1);
        issue("divu_100_7", OP_DIVU,  32'h00000064, 32'h00000007,
              DIV_EN ? 32'h00000002 : 32'h0, DIV_EN ? 32'h0000000E : 32'h0, DIV_EN ? 33 : 1);
        issue("div_zero",   OP_DIV,   32'h00000005, 32'h00000000,
              DIV_EN ? 32'h00000005 : 32'h0, DIV_EN ? 32'hFFFFFFFF : 32'h0, DIV_EN ? 33 : 1);
        issue("divu_zero",  OP_DIVU,  32'h80000003, 32'h00000000,
              DIV_EN ? 32'h80000003 : 32'h0, DIV_EN ? 32'hFFFFFFFF : 32'h0, DIV_EN ? 33 : 1);
        issue("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF,
              DIV_EN ? 32'h00000000 : 32'h0, DIV_EN ? 32'h80000000 : 32'h0, DIV_EN ? 33 : 1);
        issue("div_9_3",    OP_DIV,   32'h00000009, 32'h00000003,
              DIV_EN ? 32'h00000000 : 32'h0, DIV_EN ? 32'h00000003 : 32'h0, DIV_EN ? 33 : 1);
        issue("divu_big",   OP_DIVU,  32'hFFFFFFFF, 32'h80000001,
              DIV_EN ? 32'h7FFFFFFE : 32'h0, DIV_EN ? 32'h00000001 : 32'h0, DIV_EN ? 33 : 1);
        issue("div_pn",     OP_DIV,   32'h00000064, 32'hFFFFFFF9,
              DIV_EN ? 32'h00000002 : 32'h0, DIV_EN ? 32'hFFFFFFF2 : 32'h0, DIV_EN ? 33 : 1);

        // A start pulse at cycle 5 of an operation must be dropped.
        issue("mult_pulse", OP_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 33);
        repeat (4) @(negedge clock);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'hFFFFFFFF;
        b     = 32'h00000002;
        @(negedge clock);
        start = 1'b0;

        // Reset at cycle 10 aborts the operation without a done.
        issue("mult_abort", OP_MULTU, 32'h12345678, 32'h00000009, 32'h0, 32'h0, 33, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);

        issue("mult_6x7",   OP_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 33);
        issue("multu_hi",   OP_MULTU, 32'h80000000, 32'h00000004, 32'h00000002, 32'h00000000, 33);

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
